// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register.
//   op_t    : command opcodes sampled with start
//   state_t : control FSM states (IDLE / RUN / DONE)
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SHL   = 3'd2,
    OP_SHR   = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops whose run length comes from the count input; the rest take one step.
  function automatic logic op_uses_count(input op_t o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
           (o == OP_ROR) || (o == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One-step combinational shift datapath.
//   q_i  : current register value
//   op_i : latched opcode
//   si_i : serial fill bits for SHL/SHR
//   q_o  : register value after one step (q_i for non-shift ops)
//   so_o : bits that leave the register on this step (0 for non-shift ops)
// WIDTH >= 2, 1 <= STEP < WIDTH.
module shift_step_unit
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q_i,
  input  op_t              op_i,
  input  logic [STEP-1:0]  si_i,
  output logic [WIDTH-1:0] q_o,
  output logic [STEP-1:0]  so_o
);

  always_comb begin
    q_o  = q_i;
    so_o = '0;
    case (op_i)
      OP_SHL: begin
        q_o  = {q_i[WIDTH-1-STEP:0], si_i};
        so_o = q_i[WIDTH-1 -: STEP];
      end
      OP_SHR: begin
        q_o  = {si_i, q_i[WIDTH-1:STEP]};
        so_o = q_i[STEP-1:0];
      end
      OP_ROL: begin
        q_o  = {q_i[WIDTH-1-STEP:0], q_i[WIDTH-1 -: STEP]};
        so_o = q_i[WIDTH-1 -: STEP];
      end
      OP_ROR: begin
        q_o  = {q_i[STEP-1:0], q_i[WIDTH-1:STEP]};
        so_o = q_i[STEP-1:0];
      end
      OP_ASR: begin
        q_o  = {{STEP{q_i[WIDTH-1]}}, q_i[WIDTH-1:STEP]};
        so_o = q_i[STEP-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst commands.
//   clk, rst          : clock, async active-high reset
//   start/op/count    : command request, sampled only while ready
//   pdata             : parallel load value (sampled with start)
//   si                : serial fill, sampled live on every RUN edge
//   ready/busy/done   : IDLE / RUN / DONE state decode
//   q                 : register contents
//   so                : bits leaving on the next step, 0 outside RUN
// One command occupies k+2 cycles: accept, k step edges, one DONE cycle.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] pdata,
  input  logic [STEP-1:0]  si,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [STEP-1:0]  so
);

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] pdata_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] step_q;
  logic [STEP-1:0]  step_so;
  op_t              op_in;

  assign op_in = op_t'(op);

  shift_step_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .q_i  (q_q),
    .op_i (op_q),
    .si_i (si),
    .q_o  (step_q),
    .so_o (step_so)
  );

  // LOAD/CLEAR are handled here so the step unit stays a pure shifter.
  always_comb begin
    q_d = step_q;
    case (op_q)
      OP_LOAD:  q_d = pdata_q;
      OP_CLEAR: q_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      pdata_q <= '0;
      q_q     <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_in;
            pdata_q <= pdata;
            if (op_uses_count(op_in)) begin
              rem_q   <= count;
              // A zero-length burst skips RUN entirely and leaves q alone.
              state_q <= (count == '0) ? ST_DONE : ST_RUN;
            end else begin
              rem_q   <= CNT_W'(1);
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          q_q   <= q_d;
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign q     = q_q;
  assign so    = busy ? step_so : '0;

endmodule
